// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and vector bases.
package cp0_pkg;

  // {rd[4:0], sel[2:0]}
  localparam logic [7:0] CR_INDEX    = 8'h00;
  localparam logic [7:0] CR_RANDOM   = 8'h08;
  localparam logic [7:0] CR_ENTRYLO0 = 8'h10;
  localparam logic [7:0] CR_ENTRYLO1 = 8'h18;
  localparam logic [7:0] CR_BADVADDR = 8'h40;
  localparam logic [7:0] CR_COUNT    = 8'h48;
  localparam logic [7:0] CR_ENTRYHI  = 8'h50;
  localparam logic [7:0] CR_COMPARE  = 8'h58;
  localparam logic [7:0] CR_STATUS   = 8'h60;
  localparam logic [7:0] CR_CAUSE    = 8'h68;
  localparam logic [7:0] CR_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] VEC_BASE_BEV1   = 32'hBFC0_0200;
  localparam logic [31:0] VEC_BASE_BEV0   = 32'h8000_0000;
  localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
  localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;

  function automatic logic exc_loads_badvaddr(input logic [4:0] code);
    return (code >= EXC_MOD) && (code <= EXC_ADES);
  endfunction

  function automatic logic exc_loads_vpn2(input logic [4:0] code);
    return (code >= EXC_MOD) && (code <= EXC_TLBS);
  endfunction

  function automatic logic [31:0] exc_vector(input logic bev, input logic refill);
    logic [31:0] base;
    base = bev ? VEC_BASE_BEV1 : VEC_BASE_BEV0;
    return base + (refill ? VEC_OFF_REFILL : VEC_OFF_GENERAL);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with prescaler and timer-interrupt flag.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned TIMER_DIV   = 2
) (
  input  logic                      cp0_clk,
  input  logic                      reset,
  input  logic [ISSUE_WIDTH-1:0]    c0_we_i,
  input  logic [8*ISSUE_WIDTH-1:0]  c0_addr_i,
  input  logic [32*ISSUE_WIDTH-1:0] c0_wdata_i,
  output logic [31:0]               count_o,
  output logic [31:0]               compare_o,
  output logic                      ti_o
);

  localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      count_d = count_q + 32'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    // Compare==0 means the timer is disarmed.
    if ((compare_q != 32'd0) && (count_q == compare_q)) ti_d = 1'b1;
    // Ascending lane order lets the youngest writer win.
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (c0_we_i[i]) begin
        if (c0_addr_i[i*8 +: 8] == CR_COUNT) begin
          count_d = c0_wdata_i[i*32 +: 32];
          presc_d = '0;
        end else if (c0_addr_i[i*8 +: 8] == CR_COMPARE) begin
          compare_d = c0_wdata_i[i*32 +: 32];
          ti_d      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge cp0_clk) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_mp.sv
// Multi-issue MIPS32 CP0 register file: mtc0/mfc0 lanes, exception/eret commit,
// TLB interface registers, interrupt request and exception vector.
module cp0_mp
  import cp0_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned TIMER_DIV   = 2,
  localparam int unsigned IDX_W      = $clog2(TLB_ENTRIES)
) (
  input  logic                      cp0_clk,
  input  logic                      reset,
  input  logic [ISSUE_WIDTH-1:0]    c0_we,
  input  logic [8*ISSUE_WIDTH-1:0]  c0_addr,
  input  logic [32*ISSUE_WIDTH-1:0] c0_wdata,
  output logic [32*ISSUE_WIDTH-1:0] c0_rdata,
  input  logic                      ex_valid,
  input  logic [4:0]                ex_code,
  input  logic                      ex_refill,
  input  logic                      ex_bd,
  input  logic [31:0]               ex_pc,
  input  logic [31:0]               ex_badvaddr,
  input  logic                      eret,
  input  logic [5:0]                ext_int,
  input  logic                      tlbp_valid,
  input  logic                      tlbp_hit,
  input  logic [IDX_W-1:0]          tlbp_index,
  input  logic                      tlbr_valid,
  input  logic [31:0]               tlbr_hi,
  input  logic [31:0]               tlbr_lo0,
  input  logic [31:0]               tlbr_lo1,
  output logic                      has_int,
  output logic [31:0]               epc,
  output logic [31:0]               ex_entry,
  output logic [IDX_W-1:0]          cp0_index,
  output logic [IDX_W-1:0]          cp0_random,
  output logic [31:0]               cp0_entryhi,
  output logic [31:0]               cp0_entrylo0,
  output logic [31:0]               cp0_entrylo1
);

  localparam logic BEV = 1'b1;
  localparam logic [IDX_W-1:0] RANDOM_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic             bd_q, bd_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [5:0]       ext_int_q;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      badvaddr_q, badvaddr_d;
  logic             index_p_q, index_p_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [18:0]      vpn2_q, vpn2_d;
  logic [7:0]       asid_q, asid_d;
  logic [25:0]      lo0_q, lo0_d;
  logic [25:0]      lo1_q, lo1_d;

  logic [31:0] count, compare;
  logic        ti;

  cp0_timer #(
    .ISSUE_WIDTH (ISSUE_WIDTH),
    .TIMER_DIV   (TIMER_DIV)
  ) u_timer (
    .cp0_clk    (cp0_clk),
    .reset      (reset),
    .c0_we_i    (c0_we),
    .c0_addr_i  (c0_addr),
    .c0_wdata_i (c0_wdata),
    .count_o    (count),
    .compare_o  (compare),
    .ti_o       (ti)
  );

  // Lowest priority first; each later stage overrides the previous one.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    index_p_d  = index_p_q;
    index_d    = index_q;
    vpn2_d     = vpn2_q;
    asid_d     = asid_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    random_d   = (random_q == '0) ? RANDOM_MAX : random_q - 1'b1;

    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (c0_we[i]) begin
        case (c0_addr[i*8 +: 8])
          CR_INDEX:    index_d = c0_wdata[i*32 +: IDX_W];
          CR_ENTRYLO0: lo0_d   = c0_wdata[i*32 +: 26];
          CR_ENTRYLO1: lo1_d   = c0_wdata[i*32 +: 26];
          CR_ENTRYHI: begin
            vpn2_d = c0_wdata[i*32+13 +: 19];
            asid_d = c0_wdata[i*32 +: 8];
          end
          CR_STATUS: begin
            im_d  = c0_wdata[i*32+8 +: 8];
            exl_d = c0_wdata[i*32+1];
            ie_d  = c0_wdata[i*32];
          end
          CR_CAUSE: ip_sw_d = c0_wdata[i*32+8 +: 2];
          CR_EPC:   epc_d   = c0_wdata[i*32 +: 32];
          default: ;
        endcase
      end
    end

    if (tlbp_valid) begin
      index_p_d = !tlbp_hit;
      if (tlbp_hit) index_d = tlbp_index;
    end
    if (tlbr_valid) begin
      vpn2_d = tlbr_hi[31:13];
      asid_d = tlbr_hi[7:0];
      lo0_d  = tlbr_lo0[25:0];
      lo1_d  = tlbr_lo1[25:0];
    end

    if (eret) exl_d = 1'b0;

    if (ex_valid) begin
      exl_d     = 1'b1;
      exccode_d = ex_code;
      // A nested exception keeps the original return context.
      if (!exl_q) begin
        bd_d  = ex_bd;
        epc_d = ex_bd ? ex_pc - 32'd4 : ex_pc;
      end
      if (exc_loads_badvaddr(ex_code)) badvaddr_d = ex_badvaddr;
      if (exc_loads_vpn2(ex_code))     vpn2_d     = ex_badvaddr[31:13];
    end
  end

  always_ff @(posedge cp0_clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ext_int_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      index_p_q  <= 1'b0;
      index_q    <= '0;
      random_q   <= RANDOM_MAX;
      vpn2_q     <= '0;
      asid_q     <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ext_int_q  <= ext_int;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      index_p_q  <= index_p_d;
      index_q    <= index_d;
      random_q   <= random_d;
      vpn2_q     <= vpn2_d;
      asid_q     <= asid_d;
      lo0_q      <= lo0_d;
      lo1_q      <= lo1_d;
    end
  end

  logic [7:0]  ip;
  logic [31:0] status_w, cause_w, index_w, random_w, entryhi_w, lo0_w, lo1_w;

  assign ip        = {ext_int_q[5] | ti, ext_int_q[4:0], ip_sw_q};
  assign status_w  = {9'd0, BEV, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_w   = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'd0};
  assign index_w   = {index_p_q, {(31-IDX_W){1'b0}}, index_q};
  assign random_w  = {{(32-IDX_W){1'b0}}, random_q};
  assign entryhi_w = {vpn2_q, 5'd0, asid_q};
  assign lo0_w     = {6'd0, lo0_q};
  assign lo1_w     = {6'd0, lo1_q};

  always_comb begin
    c0_rdata = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      case (c0_addr[i*8 +: 8])
        CR_INDEX:    c0_rdata[i*32 +: 32] = index_w;
        CR_RANDOM:   c0_rdata[i*32 +: 32] = random_w;
        CR_ENTRYLO0: c0_rdata[i*32 +: 32] = lo0_w;
        CR_ENTRYLO1: c0_rdata[i*32 +: 32] = lo1_w;
        CR_BADVADDR: c0_rdata[i*32 +: 32] = badvaddr_q;
        CR_COUNT:    c0_rdata[i*32 +: 32] = count;
        CR_ENTRYHI:  c0_rdata[i*32 +: 32] = entryhi_w;
        CR_COMPARE:  c0_rdata[i*32 +: 32] = compare;
        CR_STATUS:   c0_rdata[i*32 +: 32] = status_w;
        CR_CAUSE:    c0_rdata[i*32 +: 32] = cause_w;
        CR_EPC:      c0_rdata[i*32 +: 32] = epc_q;
        default: ;
      endcase
    end
  end

  assign has_int      = (|(ip & im_q)) && ie_q && !exl_q;
  assign epc          = epc_q;
  // Vector must use the pre-exception EXL, so it is combinational on ex_refill.
  assign ex_entry     = exc_vector(BEV, ex_refill && !exl_q);
  assign cp0_index    = index_q;
  assign cp0_random   = random_q;
  assign cp0_entryhi  = entryhi_w;
  assign cp0_entrylo0 = lo0_w;
  assign cp0_entrylo1 = lo1_w;

  logic unused_tlbr;
  assign unused_tlbr = ^{tlbr_hi[12:8], tlbr_lo0[31:26], tlbr_lo1[31:26]};

endmodule

// File: tb/tb_cp0_mp.sv
// Directed self-checking bench for cp0_mp (ISSUE_WIDTH=2, TLB_ENTRIES=16, TIMER_DIV=2).
module tb_cp0_mp;

  localparam int W = 2;

  logic          cp0_clk = 1'b0;
  logic          reset;
  logic [W-1:0]  c0_we;
  logic [8*W-1:0]  c0_addr;
  logic [32*W-1:0] c0_wdata;
  logic [32*W-1:0] c0_rdata;
  logic          ex_valid, ex_refill, ex_bd, eret;
  logic [4:0]    ex_code;
  logic [31:0]   ex_pc, ex_badvaddr;
  logic [5:0]    ext_int;
  logic          tlbp_valid, tlbp_hit, tlbr_valid;
  logic [3:0]    tlbp_index;
  logic [31:0]   tlbr_hi, tlbr_lo0, tlbr_lo1;
  logic          has_int;
  logic [31:0]   epc, ex_entry, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [3:0]    cp0_index, cp0_random;

  int tests = 0;
  int fails = 0;
  logic [31:0] r;

  always #5 cp0_clk = ~cp0_clk;

  cp0_mp #(.ISSUE_WIDTH(2), .TLB_ENTRIES(16), .TIMER_DIV(2)) dut (
    .cp0_clk(cp0_clk), .reset(reset), .c0_we(c0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .c0_rdata(c0_rdata), .ex_valid(ex_valid), .ex_code(ex_code),
    .ex_refill(ex_refill), .ex_bd(ex_bd), .ex_pc(ex_pc), .ex_badvaddr(ex_badvaddr),
    .eret(eret), .ext_int(ext_int), .tlbp_valid(tlbp_valid), .tlbp_hit(tlbp_hit),
    .tlbp_index(tlbp_index), .tlbr_valid(tlbr_valid), .tlbr_hi(tlbr_hi),
    .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1), .has_int(has_int), .epc(epc),
    .ex_entry(ex_entry), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1)
  );

  task automatic tick();
    @(posedge cp0_clk);
    #1;
  endtask

  task automatic wr(input int lane, input logic [7:0] a, input logic [31:0] d);
    c0_we[lane]           = 1'b1;
    c0_addr[lane*8 +: 8]  = a;
    c0_wdata[lane*32 +: 32] = d;
  endtask

  task automatic idle();
    c0_we = '0; ex_valid = 0; eret = 0; tlbp_valid = 0; tlbr_valid = 0;
    ex_refill = 0; ex_bd = 0;
  endtask

  task automatic rd(input int lane, input logic [7:0] a, output logic [31:0] d);
    c0_addr[lane*8 +: 8] = a;
    #1;
    d = c0_rdata[lane*32 +: 32];
  endtask

  task automatic test_reset();
    reset = 1; idle(); c0_addr = '0; c0_wdata = '0; ex_code = 0; ex_pc = 0;
    ex_badvaddr = 0; ext_int = 0; tlbp_hit = 0; tlbp_index = 0;
    tlbr_hi = 0; tlbr_lo0 = 0; tlbr_lo1 = 0;
    tick(); tick();
    rd(0, 8'h60, r);
    tests++; if (r !== 32'h0040_0000) begin fails++; $display("FAIL reset_status got %h exp %h", r, 32'h0040_0000); end
    tests++; if (cp0_random !== 4'hF) begin fails++; $display("FAIL reset_random got %h exp f", cp0_random); end
    tests++; if (ex_entry !== 32'hBFC0_0380) begin fails++; $display("FAIL reset_ex_entry got %h exp bfc00380", ex_entry); end
    tests++; if ({has_int, epc, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1} !== '0) begin
      fails++; $display("FAIL reset_zero_outs got %b/%h/%h/%h", has_int, epc, cp0_index, cp0_entryhi); end
    rd(1, 8'h20, r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL unmapped_read got %h exp 0", r); end
    reset = 0;
    repeat (15) tick();
    tests++; if (cp0_random !== 4'h0) begin fails++; $display("FAIL random_zero got %h exp 0", cp0_random); end
    tick();
    rd(1, 8'h08, r);
    tests++; if (r !== 32'h0000_000F) begin fails++; $display("FAIL random_wrap got %h exp f", r); end
  endtask

  task automatic test_epc_priority();
    wr(0, 8'h70, 32'h1000); wr(1, 8'h70, 32'h2000);
    #1;
    tests++; if (c0_rdata[31:0] !== 32'h0) begin fails++; $display("FAIL same_cycle_invisible got %h exp 0", c0_rdata[31:0]); end
    tick(); idle();
    rd(1, 8'h70, r);
    tests++; if (epc !== 32'h2000 || r !== 32'h2000) begin fails++; $display("FAIL epc_lane_prio got %h/%h exp 2000", epc, r); end
    wr(0, 8'h70, 32'h1000); wr(1, 8'h70, 32'h2000);
    ex_valid = 1; ex_code = 5'd8; ex_pc = 32'h3000; ex_bd = 1;
    tick(); idle();
    tests++; if (epc !== 32'h2FFC) begin fails++; $display("FAIL epc_ex_bd got %h exp 2ffc", epc); end
    rd(0, 8'h68, r);
    tests++; if (r !== 32'h8000_0020) begin fails++; $display("FAIL cause_bd got %h exp 80000020", r); end
    rd(1, 8'h60, r);
    tests++; if (r !== 32'h0040_0002) begin fails++; $display("FAIL status_exl_set got %h exp 00400002", r); end
    eret = 1; tick(); idle();
    rd(1, 8'h60, r);
    tests++; if (r !== 32'h0040_0000) begin fails++; $display("FAIL eret_clears got %h exp 00400000", r); end
  endtask

  task automatic test_nested_ex();
    ex_valid = 1; ex_code = 5'd8; ex_pc = 32'h5000; tick(); idle();
    tests++; if (epc !== 32'h5000) begin fails++; $display("FAIL epc_first got %h exp 5000", epc); end
    ex_refill = 1; #1;
    tests++; if (ex_entry !== 32'hBFC0_0380) begin fails++; $display("FAIL vec_refill_exl got %h exp bfc00380", ex_entry); end
    ex_valid = 1; ex_code = 5'd12; ex_pc = 32'h4000; eret = 1;
    tick(); idle();
    tests++; if (epc !== 32'h5000) begin fails++; $display("FAIL epc_nested got %h exp 5000", epc); end
    rd(0, 8'h68, r);
    tests++; if (r !== 32'h0000_0030) begin fails++; $display("FAIL cause_nested got %h exp 00000030", r); end
    rd(0, 8'h60, r);
    tests++; if (r !== 32'h0040_0002) begin fails++; $display("FAIL ex_over_eret got %h exp 00400002", r); end
    eret = 1; tick(); idle();
  endtask

  task automatic test_timer();
    wr(0, 8'h58, 32'd10); wr(1, 8'h48, 32'd0);
    tick(); idle();
    rd(0, 8'h48, r);
    tests++; if (r !== 32'd0) begin fails++; $display("FAIL count_load got %0d exp 0", r); end
    repeat (20) tick();
    rd(0, 8'h48, r);
    tests++; if (r !== 32'd10) begin fails++; $display("FAIL count_div got %0d exp 10", r); end
    rd(1, 8'h68, r);
    tests++; if (r[30] !== 1'b0) begin fails++; $display("FAIL ti_early got %b exp 0", r[30]); end
    tick();
    rd(1, 8'h68, r);
    tests++; if ((r & 32'h4000_8000) !== 32'h4000_8000) begin fails++; $display("FAIL ti_rise got %h exp 40008000", r & 32'h4000_8000); end
    tests++; if (has_int !== 1'b0) begin fails++; $display("FAIL has_int_masked got %b exp 0", has_int); end
    wr(0, 8'h60, 32'h0000_8001); tick(); idle();
    tests++; if (has_int !== 1'b1) begin fails++; $display("FAIL has_int_timer got %b exp 1", has_int); end
    wr(1, 8'h58, 32'h100); tick(); idle();
    rd(1, 8'h68, r);
    tests++; if (r[30] !== 1'b0 || has_int !== 1'b0) begin fails++; $display("FAIL ti_clear got %b/%b exp 0/0", r[30], has_int); end
  endtask

  task automatic test_ext_int();
    ext_int = 6'b000100;
    rd(0, 8'h68, r);
    tests++; if (r[12] !== 1'b0) begin fails++; $display("FAIL ext_int_delay got %b exp 0", r[12]); end
    tick();
    rd(0, 8'h68, r);
    tests++; if ((r & 32'h0000_FF00) !== 32'h0000_1000) begin fails++; $display("FAIL ext_int_ip got %h exp 00001000", r & 32'h0000_FF00); end
    wr(0, 8'h60, 32'h0000_1001); tick(); idle();
    tests++; if (has_int !== 1'b1) begin fails++; $display("FAIL has_int_ext got %b exp 1", has_int); end
    ext_int = 0; wr(1, 8'h68, 32'hFFFF_FFFF); tick(); idle();
    rd(0, 8'h68, r);
    tests++; if (r !== 32'h0000_0330 || has_int !== 1'b0) begin fails++; $display("FAIL cause_write got %h/%b exp 00000330/0", r, has_int); end
  endtask

  task automatic test_tlb();
    tlbp_valid = 1; tlbp_hit = 0; tlbp_index = 4'd3; wr(0, 8'h00, 32'd9);
    tick(); idle();
    rd(0, 8'h00, r);
    tests++; if (r !== 32'h8000_0009) begin fails++; $display("FAIL tlbp_miss got %h exp 80000009", r); end
    tlbp_valid = 1; tlbp_hit = 1; tlbp_index = 4'd5; wr(1, 8'h00, 32'd7);
    tick(); idle();
    rd(0, 8'h00, r);
    tests++; if (r !== 32'h0000_0005 || cp0_index !== 4'd5) begin fails++; $display("FAIL tlbp_hit got %h/%h exp 00000005/5", r, cp0_index); end
    tlbr_valid = 1; tlbr_hi = 32'hFFFF_FFFF; tlbr_lo0 = 32'hFFFF_FFFF; tlbr_lo1 = 32'hAAAA_AAAA;
    wr(0, 8'h10, 32'h1234_5678);
    tick(); idle();
    tests++; if (cp0_entryhi !== 32'hFFFF_E0FF) begin fails++; $display("FAIL tlbr_hi got %h exp ffffe0ff", cp0_entryhi); end
    tests++; if (cp0_entrylo0 !== 32'h03FF_FFFF) begin fails++; $display("FAIL tlbr_lo0 got %h exp 03ffffff", cp0_entrylo0); end
    rd(1, 8'h18, r);
    tests++; if (r !== 32'h02AA_AAAA) begin fails++; $display("FAIL tlbr_lo1 got %h exp 02aaaaaa", r); end
  endtask

  task automatic test_refill();
    ex_valid = 1; ex_code = 5'd2; ex_refill = 1; ex_badvaddr = 32'h1234_5678; ex_pc = 32'h6000;
    #1;
    tests++; if (ex_entry !== 32'hBFC0_0200) begin fails++; $display("FAIL vec_refill got %h exp bfc00200", ex_entry); end
    tick(); idle();
    rd(0, 8'h40, r);
    tests++; if (r !== 32'h1234_5678) begin fails++; $display("FAIL badvaddr got %h exp 12345678", r); end
    tests++; if (cp0_entryhi !== 32'h1234_40FF) begin fails++; $display("FAIL vpn2 got %h exp 123440ff", cp0_entryhi); end
    tests++; if (epc !== 32'h6000 || ex_entry !== 32'hBFC0_0380) begin fails++; $display("FAIL refill_epc_vec got %h/%h exp 6000/bfc00380", epc, ex_entry); end
  endtask

  task automatic test_mid_reset();
    reset = 1; wr(0, 8'h70, 32'hDEAD); ex_valid = 1; ex_code = 5'd2;
    tick(); idle(); reset = 0;
    rd(0, 8'h60, r);
    tests++; if (r !== 32'h0040_0000 || epc !== 32'h0) begin fails++; $display("FAIL mid_reset got %h/%h exp 00400000/0", r, epc); end
    tests++; if (cp0_entryhi !== 32'h0 || cp0_random !== 4'hF) begin fails++; $display("FAIL mid_reset_tlb got %h/%h exp 0/f", cp0_entryhi, cp0_random); end
  endtask

  initial begin
    test_reset();
    test_epc_priority();
    test_nested_ex();
    test_timer();
    test_ext_int();
    test_tlb();
    test_refill();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cp0_mp.md
# cp0_mp

Parametrised MIPS32 coprocessor-0 register file for the multi-issue pipeline. It accepts up to ISSUE_WIDTH mtc0/mfc0 operations per cycle and one committed exception or eret. It exports Status/Cause/EPC/BadVAddr/Count/Compare and the TLB interface registers (Index, Random, EntryHi, EntryLo0/1), takes TLBP/TLBR results, and computes the interrupt request and the exception entry vector for the fetch stage.

## Interface
Parameters:
- ISSUE_WIDTH, 2, number of mtc0/mfc0 lanes; lane ISSUE_WIDTH-1 is youngest in program order
- TLB_ENTRIES, 16, TLB depth, power of two, 2..64; IDX_W = $clog2(TLB_ENTRIES)
- TIMER_DIV, 2, Count increments once every TIMER_DIV cycles, ≥1

Ports:
- cp0_clk  in  1  clock
- reset  in  1  synchronous, active-high
- c0_we  in  ISSUE_WIDTH  per-lane mtc0 write enable
- c0_addr  in  8*ISSUE_WIDTH  per-lane {rd[4:0],sel[2:0]}
- c0_wdata  in  32*ISSUE_WIDTH  per-lane write data
- c0_rdata  out  32*ISSUE_WIDTH  per-lane mfc0 read data
- ex_valid  in  1  committed exception
- ex_code  in  5  ExcCode
- ex_refill  in  1  TLB refill (miss) flavour of TLBL/TLBS
- ex_bd  in  1  excepting instruction is in a delay slot
- ex_pc  in  32  PC of excepting instruction
- ex_badvaddr  in  32  faulting virtual address
- eret  in  1  committed eret
- ext_int  in  6  hardware interrupt lines, level
- tlbp_valid  in  1  TLBP result valid
- tlbp_hit / tlbp_index  in  1 / IDX_W  probe result
- tlbr_valid  in  1  TLBR result valid
- tlbr_hi / tlbr_lo0 / tlbr_lo1  in  32 each  entry read from TLB
- has_int  out  1  interrupt pending and enabled
- epc  out  32  EPC
- ex_entry  out  32  exception vector
- cp0_index / cp0_random  out  IDX_W each  TLBWI/TLBWR index
- cp0_entryhi / cp0_entrylo0 / cp0_entrylo1  out  32 each

## Operation
- Write priority per field: ex_valid > eret > tlbr/tlbp > highest-numbered lane writing that address > lower lanes > hardware update.
- mfc0 reads are combinational from registers. A same-cycle write is not visible. Unmapped addresses read 0.
- Status: BEV fixed 1. IM[7:0] and IE are writable, reset 0. EXL is writable, reset 0, set by ex_valid, cleared by eret (ex_valid wins over eret).
- Cause: BD and EPC are updated only if ex_valid && !EXL. EPC = ex_bd ? ex_pc-4 : ex_pc. ExcCode is updated on every ex_valid. IP[1:0] is writable. IP[6:2] = ext_int[4:0] registered each cycle. IP[7] = ext_int[5] | TI. TI is set the cycle after Count==Compare and cleared by a Compare write.
- BadVAddr is written on ex_valid with ExcCode ∈ {1,2,3,4,5}. EntryHi.VPN2 is written on ex_valid with ExcCode ∈ {1,2,3}.
- Index: P is set to !tlbp_hit on tlbp_valid, and index = tlbp_index on a hit. Writable index field is IDX_W bits.
- Random: reset TLB_ENTRIES-1, decrements every cycle and wraps to TLB_ENTRIES-1 after 0. Read-only.
- EntryLo: PFN[25:6], C[5:3], D, V, G are writable. tlbr_valid loads EntryHi{VPN2,ASID} and both EntryLo. G is taken per-lo from tlbr data.
- has_int = |(IP & IM) && IE && !EXL.
- ex_entry:
  - BEV=1: 0xBFC00200 if ex_refill && !EXL, else 0xBFC00380.
  - BEV=0: 0x80000000 / 0x80000180 for the same two cases.

## Timing
- All state updates at the cp0_clk edge where the request is presented. Outputs reflect the new value one cycle later.
- Reset values:
  - c0_rdata per field reset values
  - has_int 0
  - epc 0
  - ex_entry 0xBFC00380
  - cp0_index 0
  - cp0_random TLB_ENTRIES-1
  - entryhi/lo 0
  - Count 0, Compare 0, prescaler 0
- Count increments when prescaler == TIMER_DIV-1, after which the prescaler returns to 0. A Count write loads the value and clears the prescaler. Count wraps 0xFFFFFFFF→0.
- Count==Compare is ignored when Compare == 0.
- Reset mid-operation overrides all concurrent requests.

## Structure
- Package cp0_pkg holds:
  - the CR_* addresses (Index 0x00, Random 0x08, EntryLo0 0x10, EntryLo1 0x18, BadVAddr 0x40, Count 0x48, EntryHi 0x50, Compare 0x58, Status 0x60, Cause 0x68, EPC 0x70)
  - ExcCode constants
  - vector base constants
- Sub-module cp0_timer: prescaler, Count, Compare, TI, and its lane-priority write logic.

## Test plan
- Reset, then read Status on lane 0 -> 0x00400000. Random = TLB_ENTRIES-1. ex_entry = 0xBFC00380.
- Same cycle: lane0 writes EPC=0x1000 and lane1 writes EPC=0x2000 -> EPC=0x2000. Repeat with ex_valid, ex_pc=0x3000, bd=1 -> EPC=0x2FFC.
- Compare=10, Count=0, TIMER_DIV=2 -> TI rises the cycle after Count==10. Then write IM=0x80, IE=1 -> has_int=1. Compare write -> TI=0.
- ex_valid with EXL=1 and ex_pc=0x4000 -> EPC unchanged, ExcCode updated. Simultaneous eret -> EXL stays 1.
- tlbp_valid with hit=0 -> Index=0x80000000. Then hit=1, index=5 -> 0x00000005. tlbr_valid -> EntryHi/Lo equal tlbr_* masked to implemented fields.
- ex_valid, ExcCode=2, ex_refill=1, EXL=0 -> ex_entry=0xBFC00200, BadVAddr and VPN2 loaded.
